// File: rtl/fusion_stream_ctrl_if.sv
// fusion_stream_ctrl_if: AXI-Stream handshake bundle between the fusion controller and its neighbours
interface fusion_stream_ctrl_if;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;
  modport slave (
    input  s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast
  );
  modport master (
    output s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/fusion_stream_ctrl.sv
// fusion_stream_ctrl: pipeline-enable flow control, per-stage validity, pixel/frame counting and tlast for temporal fusion
module fusion_stream_ctrl #(
  parameter int HIM_LEN           = 520,
  parameter int HIM_WID           = 520,
  parameter int HNO_IMAGES        = 16,
  parameter int LOG2_NO_OF_IMAGES = 4,
  parameter int PIPELINE_LATENCY  = 20
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset,
  input  logic                         start,
  input  logic                         abort,
  fusion_stream_ctrl_if.slave          axis,
  output logic                         pipe_en,
  output logic [LOG2_NO_OF_IMAGES-1:0] frame_idx,
  output logic                         first_frame,
  output logic                         busy,
  output logic                         frame_done
);
  localparam int FRAME_PIX = HIM_LEN * HIM_WID;
  localparam int CW = FRAME_PIX > 1 ? $clog2(FRAME_PIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIX - 1);
  localparam logic [LOG2_NO_OF_IMAGES-1:0] LAST_IDX = LOG2_NO_OF_IMAGES'(HNO_IMAGES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                         r_state;
  logic [PIPELINE_LATENCY-1:0]    r_vld;
  logic [CW-1:0]                  r_in_cnt;
  logic [CW-1:0]                  r_out_cnt;
  logic [LOG2_NO_OF_IMAGES-1:0]   r_frame_idx;
  logic                           r_frame_done;
  logic                           w_act;
  logic                           w_vld_last;
  logic                           w_pipe_en;
  logic                           w_in_hs;
  logic                           w_out_hs;
  logic                           w_tlast;

  assign w_act      = r_state != IDLE;
  assign w_vld_last = r_vld[PIPELINE_LATENCY-1];
  // a valid head stage may only advance when downstream takes it
  assign w_pipe_en  = w_act & (axis.m_axis_tready | ~w_vld_last);
  assign w_in_hs    = axis.s_axis_tready & axis.s_axis_tvalid;
  assign w_out_hs   = axis.m_axis_tvalid & axis.m_axis_tready;
  assign w_tlast    = axis.m_axis_tvalid & (r_out_cnt == LAST_PIX);

  assign axis.s_axis_tready = (r_state == RUN) & w_pipe_en;
  assign axis.m_axis_tvalid = w_vld_last & w_act;
  assign axis.m_axis_tlast  = w_tlast;
  assign pipe_en            = w_pipe_en;
  assign frame_idx          = r_frame_idx;
  assign first_frame        = r_frame_idx == '0;
  assign busy               = w_act;
  assign frame_done         = r_frame_done;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state      <= IDLE;
      r_vld        <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_frame_idx  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (abort && w_act) begin
        r_state   <= IDLE;
        r_vld     <= '0;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else if (r_state == IDLE) begin
        if (start) r_state <= RUN;
      end else begin
        if (w_pipe_en) r_vld <= (r_vld << 1) | PIPELINE_LATENCY'(w_in_hs);
        if (w_in_hs) begin
          r_in_cnt <= (r_in_cnt == LAST_PIX) ? '0 : r_in_cnt + 1'b1;
          if (r_in_cnt == LAST_PIX) r_state <= DRAIN;
        end
        if (w_out_hs) begin
          r_out_cnt <= w_tlast ? '0 : r_out_cnt + 1'b1;
          if (w_tlast && r_state == DRAIN) begin
            r_frame_idx  <= (r_frame_idx == LAST_IDX) ? '0 : r_frame_idx + 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fusion_stream_ctrl.sv
// tb_fusion_stream_ctrl: directed vector table plus randomized frames checked against a token/latency reference model
module tb_fusion_stream_ctrl;
  localparam int L  = 3;
  localparam int FP = 8;
  localparam int NI = 3;

  logic       clk, rst, start, abort;
  logic       pipe_en, first_frame, busy, frame_done;
  logic [1:0] frame_idx;
  int         n_pass = 0, n_tot = 0, hs = 0;

  // reference model: accepted pixels carry the pipe_en count at acceptance
  int m_busy = 0, m_acc = 0, m_out = 0, m_idx = 0, m_done = 0, pe_cnt = 0;
  int q[$];

  typedef struct {
    logic       st, tv, tr;
    logic [8:0] e;
  } vec_t;
  vec_t tbl[14];

  fusion_stream_ctrl_if io();

  fusion_stream_ctrl #(
    .HIM_LEN(4), .HIM_WID(2), .HNO_IMAGES(NI), .LOG2_NO_OF_IMAGES(2), .PIPELINE_LATENCY(L)
  ) dut (
    .axi_clk(clk), .axi_reset(rst), .start(start), .abort(abort), .axis(io),
    .pipe_en(pipe_en), .frame_idx(frame_idx), .first_frame(first_frame),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {io.s_axis_tready, io.m_axis_tvalid, io.m_axis_tlast, pipe_en, busy,
            frame_done, first_frame, frame_idx};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(output logic [8:0] g);
    bit etv, etl, epe, esr;
    @(negedge clk);
    if (rst) begin
      m_busy = 0; m_acc = 0; m_out = 0; m_idx = 0; m_done = 0; pe_cnt = 0;
      q.delete();
    end
    etv = 0;
    if (m_busy != 0 && q.size() > 0) etv = (pe_cnt - q[0]) == L;
    etl = etv && m_out == FP - 1;
    epe = m_busy != 0 && (io.m_axis_tready || !etv);
    esr = epe && m_acc < FP;
    g = outs();
    chk("model_outs", g, {esr, etv, etl, epe, m_busy[0], m_done[0], m_idx == 0, 2'(m_idx)});
    if (io.m_axis_tvalid && io.m_axis_tready) hs++;
    if (!rst) begin
      m_done = 0;
      if (m_busy == 0) begin
        if (start) m_busy = 1;
      end else if (abort) begin
        m_busy = 0; m_acc = 0; m_out = 0;
        q.delete();
      end else begin
        if (etv && io.m_axis_tready) begin
          void'(q.pop_front());
          m_out++;
          if (m_out == FP) begin
            m_out = 0; m_acc = 0; m_idx = (m_idx + 1) % NI; m_done = 1; m_busy = 0;
          end
        end
        if (esr && io.s_axis_tvalid) begin
          q.push_back(pe_cnt);
          m_acc++;
        end
        if (epe) pe_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int mode);
    logic [8:0] g;
    bit done = 0;
    io.s_axis_tvalid = 0;
    start = 1;
    tick(g);
    start = 0;
    hs = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      io.s_axis_tvalid = mode == 2 ? (c % 2 == 0) : mode == 3 ? ($urandom_range(0, 3) != 0) : 1'b1;
      io.m_axis_tready = mode == 1 ? !(c >= 4 && c < 9) : mode == 3 ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(g);
      if (!io.m_axis_tready && g[7]) chk("stall_pe_tready", {g[8], g[5]}, 0);
      done = g[3];
    end
    chk("frame_done_seen", done, 1);
    chk("out_count", hs, FP);
  endtask

  initial begin
    logic [8:0] g;
    int saved;
    bit ok;
    rst = 1; start = 0; abort = 0;
    io.s_axis_tvalid = 0; io.m_axis_tready = 0;
    tick(g);
    tick(g);
    chk("reset_outs", g, 9'b000000100);
    rst = 0;
    tick(g);

    tbl[0] = '{1, 1, 1, 9'b000000100};
    for (int i = 1; i < 4; i++) tbl[i] = '{0, 1, 1, 9'b100110100};
    for (int i = 4; i < 9; i++) tbl[i] = '{0, 1, 1, 9'b110110100};
    tbl[9]  = '{0, 1, 1, 9'b010110100};
    tbl[10] = '{0, 1, 1, 9'b010110100};
    tbl[11] = '{0, 1, 1, 9'b011110100};
    tbl[12] = '{0, 1, 1, 9'b000001001};
    tbl[13] = '{0, 1, 1, 9'b000000001};
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st;
      io.s_axis_tvalid = tbl[i].tv;
      io.m_axis_tready = tbl[i].tr;
      tick(g);
      chk($sformatf("table_row%0d", i), g, tbl[i].e);
    end
    start = 0;

    run_frame(1);
    chk("idx_after_stall", frame_idx, 2);
    run_frame(2);
    chk("idx_after_toggle", frame_idx, 0);

    saved = frame_idx;
    io.s_axis_tvalid = 0;
    start = 1;
    tick(g);
    start = 0;
    io.s_axis_tvalid = 1; io.m_axis_tready = 1;
    for (int c = 0; c < 50 && m_acc < 5; c++) tick(g);
    chk("abort_after_5", m_acc, 5);
    abort = 1;
    tick(g);
    abort = 0;
    tick(g);
    chk("abort_busy_tvalid", {g[4], g[7]}, 0);
    chk("abort_idx_kept", frame_idx, saved);
    run_frame(0);
    chk("idx_after_abort_restart", frame_idx, (saved + 1) % NI);

    saved = frame_idx;
    start = 1;
    tick(g);
    start = 0;
    for (int c = 0; c < 50 && m_out < FP - 1; c++) tick(g);
    abort = 1;
    tick(g);
    chk("abort_on_tlast_coincident", g[6], 1);
    abort = 0;
    tick(g);
    chk("abort_tlast_no_done", {g[3], g[4]}, 0);
    chk("abort_tlast_idx_kept", frame_idx, saved);

    for (int f = 0; f < 3; f++) run_frame(3);

    start = 1;
    tick(g);
    start = 0;
    io.s_axis_tvalid = 1; io.m_axis_tready = 1;
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      tick(g);
      ok = m_acc == FP;
    end
    chk("reached_drain", ok, 1);
    io.m_axis_tready = 0;
    #2;
    rst = 1;
    #1;
    chk("async_reset_outs", outs(), 9'b000000100);
    tick(g);
    rst = 0;
    io.m_axis_tready = 1;
    tick(g);

    for (int f = 0; f < 4; f++) begin
      chk($sformatf("seq_idx%0d", f), frame_idx, f % NI);
      chk($sformatf("seq_first%0d", f), first_frame, f % NI == 0);
      run_frame(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/fusion_stream_ctrl.md
Name: fusion_stream_ctrl

Overview:
- Flow controller for the temporal-fusion pipeline (running average plus fused-image path).
- Replaces clock gating with a single pipeline enable.
- Tracks per-stage validity across the fixed PIPELINE_LATENCY, counts pixels per frame and generates m_axis_tlast on the last output pixel.
- Sequences frames modulo HNO_IMAGES and exposes the frame index to the datapath. Sits between the AXI-Stream ports and the datapath stages.

Parameters:
- HIM_LEN, 520, image line length in pixels
- HIM_WID, 520, image height in lines
- HNO_IMAGES, 16, frames per averaging window (frame index wraps here)
- LOG2_NO_OF_IMAGES, 4, width of frame_idx
- PIPELINE_LATENCY, 20, datapath stages from accepted input to output (≥1)

Ports:
- axi_clk  in  1  clock
- axi_reset  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse: begin one frame (honoured in IDLE only)
- abort  in  1  synchronous: drop current frame
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input accepted this cycle when high with tvalid
- m_axis_tvalid  out  1  output pixel valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last pixel of frame
- pipe_en  out  1  advance all datapath stages one step this cycle
- frame_idx  out  LOG2_NO_OF_IMAGES  index of frame being processed
- first_frame  out  1  frame_idx==0 (datapath seeds average)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after final output handshake

Behaviour:
- Reset values:
  - State IDLE.
  - vld shift register all 0; in_cnt=0, out_cnt=0, frame_idx=0.
  - All outputs 0 except first_frame=1.
- Local FRAME_PIX = HIM_LEN*HIM_WID. Pixel counters are $clog2(FRAME_PIX) bits wide and never exceed FRAME_PIX-1.
- vld[PIPELINE_LATENCY-1:0] tracks one valid bit per stage. vld_last = vld[PIPELINE_LATENCY-1].
- States: IDLE, RUN, DRAIN.
- IDLE:
  - pipe_en=0, s_axis_tready=0.
  - start → RUN. start in other states is ignored.
- RUN:
  - pipe_en = m_axis_tready | ~vld_last (combinational).
  - s_axis_tready = pipe_en.
  - Each pipe_en cycle: vld shifts by one, vld[0] <= s_axis_tvalid.
  - Bubbles propagate; the datapath ignores data in invalid stages.
  - in_cnt increments per input handshake.
  - Handshake with in_cnt==FRAME_PIX-1: in_cnt←0, → DRAIN.
- DRAIN:
  - Same pipe_en rule, s_axis_tready=0, vld[0] <= 0.
- Outputs:
  - m_axis_tvalid = vld_last & (state != IDLE).
  - Output handshake = m_axis_tvalid & m_axis_tready; out_cnt increments on each handshake.
  - m_axis_tlast = m_axis_tvalid & (out_cnt==FRAME_PIX-1).
- Frame completion: handshake with tlast in DRAIN → out_cnt←0; frame_idx←(frame_idx==HNO_IMAGES-1)?0:frame_idx+1; frame_done pulses next cycle; → IDLE.
- AXI rules:
  - m_axis_tvalid never drops without a handshake, since vld_last only shifts when pipe_en, and pipe_en is forced by tready while vld_last=1.
  - s_axis_tready depends combinationally on m_axis_tready; the combinational tready path is accepted by design.
- Latency: a pixel accepted at cycle t appears on m_axis_tvalid after exactly PIPELINE_LATENCY pipe_en cycles.
- Simultaneous input and output handshakes in one cycle are normal; both counters update.
- Tlast/last-input ordering:
  - A tlast handshake can occur only in DRAIN.
  - With PIPELINE_LATENCY≥1, the last input is always accepted before its output appears.
- abort (RUN or DRAIN):
  - Next cycle: IDLE, vld←0, in_cnt←0, out_cnt←0, frame_idx unchanged, no frame_done.
  - An abort coinciding with the final handshake takes priority: the frame is not counted.
- axi_reset mid-frame: immediate return to reset values, regardless of handshakes in flight.

Test Plan:
- HIM_LEN=4, HIM_WID=2, PIPELINE_LATENCY=3, tready=1, tvalid=1 continuous, start pulse:
  - 8 input handshakes.
  - First m_axis_tvalid 3 cycles after the first accept.
  - tlast on the 8th output only.
  - frame_done one cycle later.
  - frame_idx 0→1.
- Same config with m_axis_tready low for 5 cycles mid-frame:
  - pipe_en=0 and s_axis_tready=0 while vld_last=1.
  - m_axis_tvalid held high.
  - No lost or duplicated outputs (8 total).
- s_axis_tvalid toggling 1,0,1,0:
  - Bubbles propagate.
  - Outputs appear with the same gaps; out_cnt reaches 7 only after all 8 inputs emerge.
- HNO_IMAGES=3, run 4 frames:
  - frame_idx sequence 0,1,2,0.
  - first_frame high for frames 1 and 4.
- abort asserted after 5 inputs:
  - Next cycle IDLE, busy=0, m_axis_tvalid=0.
  - Next start restarts at in_cnt=0 with frame_idx unchanged.
- axi_reset asserted asynchronously mid-DRAIN:
  - All outputs at reset values immediately, without waiting for a clock edge.
  - frame_idx=0, first_frame=1.
